imm_encoder: RTL and testbench
==============================

Name: imm_encoder

Overview:
Inverse of the decode-stage immediate extractor. It takes an instruction template plus a 32-bit immediate and packs the immediate into the RV32 field layout selected by imm_e, producing finished instruction words. It also expands the LI pseudo-op into a LUI and ADDI sequence. It sits in front of the debug program-buffer / self-test instruction generator, with valid/ready handshakes on both sides.

Parameters:
XLEN, 32, datapath width; only 32 is supported.

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous active-high reset
req_valid_i  input  1  request valid
req_ready_o  output  1  request accepted when req_valid_i && req_ready_o
req_sel_i  input  imm_e  immediate format (I_IMM, I_USIMM, S_IMM, B_IMM, U_IMM, J_IMM, CSR_IMM); ignored when req_li_i=1
req_li_i  input  1  LI pseudo-op; rd taken from req_base_i[11:7]
req_base_i  input  XLEN  instruction template (opcode/rd/rs/funct); bits in immediate positions are ignored
req_imm_i  input  XLEN  immediate value
inst_valid_o  output  1  output word valid
inst_ready_i  input  1  output word consumed
inst_o  output  XLEN  encoded instruction
inst_last_o  output  1  last word of the current request
range_err_o  output  1  immediate not representable in the format; qualified by inst_valid_o

Behaviour:
- Reset (synchronous, rst_i=1): state IDLE; inst_valid_o=0, inst_o=0, inst_last_o=0, range_err_o=0, req_ready_o=0 during reset. Reset mid-sequence discards the pending word and any queued second LI word.
- FSM states: IDLE (no word held), HOLD (word held, final), HOLD_LUI (LUI held, ADDI pending).
- Accept: IDLE, or HOLD with inst_ready_i=1 (back-to-back). req_ready_o = (state==IDLE) | (state==HOLD & inst_ready_i).
- Latency: the word is registered; inst_valid_o rises the cycle after accept.
- Throughput: 1 word/cycle with inst_ready_i held high.
- Output stability: inst_o, inst_last_o and range_err_o are stable while inst_valid_o=1 and inst_ready_i=0.
- Encoding: immediate bit positions of req_base_i are cleared, then the immediate is ORed in.
  - I / I_USIMM: [31:20]=imm[11:0]
  - S: [31:25]=imm[11:5]; [11:7]=imm[4:0]
  - B: [31]=imm[12]; [7]=imm[11]; [30:25]=imm[10:5]; [11:8]=imm[4:1]
  - U: [31:12]=imm[31:12]
  - J: [31]=imm[20]; [19:12]=imm[19:12]; [20]=imm[11]; [30:21]=imm[10:1]
  - CSR: [19:15]=imm[4:0]
- range_err_o=1 under these conditions:
  - I: imm[31:11] not all equal
  - I_USIMM: imm[31:12] != 0
  - S: imm[31:11] not all equal
  - B: imm[31:12] not all equal, or imm[0]=1
  - U: imm[11:0] != 0
  - J: imm[31:20] not all equal, or imm[0]=1
  - CSR: imm[31:5] != 0
  - On error the truncated word is still emitted.
- LI expansion: hi=(imm+32'h800)[31:12] (carry out of bit 31 discarded); lo=imm[11:0].
  - Word 1: LUI rd,hi (opcode 7'b0110111), inst_last_o=0.
  - Word 2: ADDI rd,rd,lo (opcode 7'b0010011, funct3 000), inst_last_o=1.
  - HOLD_LUI to HOLD on handshake. req_ready_o=0 in HOLD_LUI.
  - range_err_o is always 0 for LI.
- An unknown sel value encodes a zero immediate (template passed through) with range_err_o=0.

Optional Feature:
TCORE_LI_OPT_EN.
- Defined:
  - LI with hi==0 emits the single word ADDI rd,x0,lo.
  - LI with lo==0 and hi!=0 emits the single word LUI rd,hi.
  - Either single word has inst_last_o=1.
- Undefined: LI always emits two words (deterministic length).

Test Plan:
- I_IMM, base=32'h00000513, imm=32'hFFFFFFFF -> inst_o=32'hFFF00513, last=1, err=0, one cycle after accept.
- B_IMM, base=32'h00000063, imm=32'hFFFFFFFC -> inst_o=32'hFE000EE3, err=0. Same with imm=32'h00001000 -> err=1.
- LI, base rd=x10 (32'h00000500), imm=32'h12345FFF -> 32'h12346537 (last=0), then 32'hFFF50513 (last=1). req_ready_o=0 between the two words.
- Backpressure: inst_ready_i=0 for 5 cycles with a word held -> inst_o/last/err unchanged, req_ready_o=0. The word is accepted on the first cycle inst_ready_i=1, and a new request is accepted in that same cycle.
- I_IMM imm=32'h00000800, base=32'h00000513 -> inst_o=32'h80000513, err=1. Assert rst_i during HOLD_LUI -> next cycle inst_valid_o=0 and no ADDI is emitted.
- LI rd=x10 imm=32'h00000123:
  - With TCORE_LI_OPT_EN -> single 32'h12300513, last=1.
  - Without -> 32'h00000537 then 32'h12350513.

Source files
------------

// File: rtl/imm_encoder_pkg.sv
// Immediate format selector shared by imm_encoder and its users.
package imm_encoder_pkg;
    typedef enum logic [2:0] {
        I_IMM   = 3'd0,
        I_USIMM = 3'd1,
        S_IMM   = 3'd2,
        B_IMM   = 3'd3,
        U_IMM   = 3'd4,
        J_IMM   = 3'd5,
        CSR_IMM = 3'd6
    } imm_e;
endpackage

// File: rtl/imm_encoder.sv
// Packs a 32-bit immediate into an RV32 instruction template and expands LI into LUI+ADDI.
// Optional macro TCORE_LI_OPT_EN shortens LI to one word when hi or lo is zero.
module imm_encoder
    import imm_encoder_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  imm_e            req_sel_i,
    input  logic            req_li_i,
    input  logic [XLEN-1:0] req_base_i,
    input  logic [XLEN-1:0] req_imm_i,
    output logic            inst_valid_o,
    input  logic            inst_ready_i,
    output logic [XLEN-1:0] inst_o,
    output logic            inst_last_o,
    output logic            range_err_o
);

    // Handshake: a transfer happens on a rising clock edge where valid && ready;
    // a producer holds valid and its payload steady until that transfer.
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_HOLD     = 2'd1;
    localparam logic [1:0] ST_HOLD_LUI = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] inst_q, inst_d;
    logic [XLEN-1:0] addi_q, addi_d;
    logic            last_q, last_d;
    logic            err_q, err_d;

    logic [XLEN-1:0] enc_word;
    logic            enc_err;
    logic [4:0]      rd;
    logic [19:0]     li_hi;
    logic [11:0]     li_lo;
    logic [XLEN-1:0] lui_word;
    logic [XLEN-1:0] addi_word;
    logic [XLEN-1:0] li_first;
    logic            li_two;
    logic            accept;

    always_comb begin
        enc_word = req_base_i;
        enc_err  = 1'b0;
        case (req_sel_i)
            I_IMM: begin
                enc_word[31:20] = req_imm_i[11:0];
                enc_err = !((&req_imm_i[31:11]) || !(|req_imm_i[31:11]));
            end
            I_USIMM: begin
                enc_word[31:20] = req_imm_i[11:0];
                enc_err = |req_imm_i[31:12];
            end
            S_IMM: begin
                enc_word[31:25] = req_imm_i[11:5];
                enc_word[11:7]  = req_imm_i[4:0];
                enc_err = !((&req_imm_i[31:11]) || !(|req_imm_i[31:11]));
            end
            B_IMM: begin
                enc_word[31]    = req_imm_i[12];
                enc_word[30:25] = req_imm_i[10:5];
                enc_word[11:8]  = req_imm_i[4:1];
                enc_word[7]     = req_imm_i[11];
                enc_err = !((&req_imm_i[31:12]) || !(|req_imm_i[31:12])) || req_imm_i[0];
            end
            U_IMM: begin
                enc_word[31:12] = req_imm_i[31:12];
                enc_err = |req_imm_i[11:0];
            end
            J_IMM: begin
                enc_word[31]    = req_imm_i[20];
                enc_word[30:21] = req_imm_i[10:1];
                enc_word[20]    = req_imm_i[11];
                enc_word[19:12] = req_imm_i[19:12];
                enc_err = !((&req_imm_i[31:20]) || !(|req_imm_i[31:20])) || req_imm_i[0];
            end
            CSR_IMM: begin
                enc_word[19:15] = req_imm_i[4:0];
                enc_err = |req_imm_i[31:5];
            end
            default: begin
                enc_word = req_base_i;
                enc_err  = 1'b0;
            end
        endcase
    end

    // Rounding up by 0x800 compensates the sign extension ADDI applies to lo.
    assign rd        = req_base_i[11:7];
    assign li_hi     = req_imm_i[31:12] + {19'd0, req_imm_i[11]};
    assign li_lo     = req_imm_i[11:0];
    assign lui_word  = {li_hi, rd, 7'b0110111};
    assign addi_word = {li_lo, rd, 3'b000, rd, 7'b0010011};

    always_comb begin
        li_first = lui_word;
        li_two   = 1'b1;
`ifdef TCORE_LI_OPT_EN
        if (li_hi == 20'd0) begin
            li_first = {li_lo, 5'd0, 3'b000, rd, 7'b0010011};
            li_two   = 1'b0;
        end else if (li_lo == 12'd0) begin
            li_two   = 1'b0;
        end
`endif
    end

    assign req_ready_o  = !rst_i && ((state_q == ST_IDLE) ||
                                     ((state_q == ST_HOLD) && inst_ready_i));
    assign accept       = req_valid_i && req_ready_o;
    assign inst_valid_o = !rst_i && (state_q != ST_IDLE);
    assign inst_o       = inst_q;
    assign inst_last_o  = last_q;
    assign range_err_o  = err_q;

    always_comb begin
        state_d = state_q;
        inst_d  = inst_q;
        addi_d  = addi_q;
        last_d  = last_q;
        err_d   = err_q;
        if (accept) begin
            if (req_li_i) begin
                inst_d  = li_first;
                addi_d  = addi_word;
                last_d  = !li_two;
                err_d   = 1'b0;
                state_d = li_two ? ST_HOLD_LUI : ST_HOLD;
            end else begin
                inst_d  = enc_word;
                last_d  = 1'b1;
                err_d   = enc_err;
                state_d = ST_HOLD;
            end
        end else if (inst_ready_i) begin
            case (state_q)
                ST_HOLD:     state_d = ST_IDLE;
                ST_HOLD_LUI: begin
                    inst_d  = addi_q;
                    last_d  = 1'b1;
                    err_d   = 1'b0;
                    state_d = ST_HOLD;
                end
                default:     state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            inst_q  <= '0;
            addi_q  <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            inst_q  <= inst_d;
            addi_q  <= addi_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_imm_encoder.sv
// Randomized and directed bench for imm_encoder with an arithmetic reference model.
module tb_imm_encoder;
    import imm_encoder_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    imm_e        req_sel_i;
    logic        req_li_i;
    logic [31:0] req_base_i;
    logic [31:0] req_imm_i;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] inst_o;
    logic        inst_last_o;
    logic        range_err_o;

    int n_cmp = 0;
    int n_bad = 0;
    logic [33:0] exp_q[$];   // {err, last, word}
    logic req_fire = 1'b0;

    imm_encoder #(.XLEN(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_sel_i(req_sel_i), .req_li_i(req_li_i),
        .req_base_i(req_base_i), .req_imm_i(req_imm_i),
        .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i),
        .inst_o(inst_o), .inst_last_o(inst_last_o), .range_err_o(range_err_o)
    );

    // clock / reset
    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit fits_signed(input logic [31:0] v, input int bits);
        longint s;
        s = longint'($signed(v));
        return (s >= -(64'sd1 <<< (bits - 1))) && (s < (64'sd1 <<< (bits - 1)));
    endfunction

    // reference model: words a request should produce, from field layouts and ranges
    function automatic void model_push(input imm_e sel, input logic li,
                                       input logic [31:0] base, input logic [31:0] imm);
        logic [31:0] w, lui, addi, hi, lo, rd;
        logic e;
        if (li) begin
            rd   = (base >> 7) & 32'h1F;
            hi   = ((imm + 32'h800) >> 12) & 32'hFFFFF;
            lo   = imm & 32'hFFF;
            lui  = (hi << 12) | (rd << 7) | 32'h37;
            addi = (lo << 20) | (rd << 15) | (rd << 7) | 32'h13;
`ifdef TCORE_LI_OPT_EN
            if (hi == 0) begin
                exp_q.push_back({1'b0, 1'b1, (lo << 20) | (rd << 7) | 32'h13});
                return;
            end
            if (lo == 0) begin
                exp_q.push_back({1'b0, 1'b1, lui});
                return;
            end
`endif
            exp_q.push_back({1'b0, 1'b0, lui});
            exp_q.push_back({1'b0, 1'b1, addi});
            return;
        end
        case (sel)
            I_IMM:   begin w = (base & 32'h000FFFFF) | ((imm & 32'hFFF) << 20); e = !fits_signed(imm, 12); end
            I_USIMM: begin w = (base & 32'h000FFFFF) | ((imm & 32'hFFF) << 20); e = imm > 32'd4095; end
            S_IMM:   begin
                w = (base & 32'h01FFF07F) | (((imm >> 5) & 32'h7F) << 25) | ((imm & 32'h1F) << 7);
                e = !fits_signed(imm, 12);
            end
            B_IMM:   begin
                w = (base & 32'h01FFF07F) | (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25)
                  | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 1) << 7);
                e = !fits_signed(imm, 13) || imm[0];
            end
            U_IMM:   begin w = (base & 32'hFFF) | (imm & 32'hFFFFF000); e = (imm & 32'hFFF) != 0; end
            J_IMM:   begin
                w = (base & 32'hFFF) | (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                  | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12);
                e = !fits_signed(imm, 21) || imm[0];
            end
            CSR_IMM: begin w = (base & 32'hFFF07FFF) | ((imm & 32'h1F) << 15); e = imm > 32'd31; end
            default: begin w = base; e = 1'b0; end
        endcase
        exp_q.push_back({e, 1'b1, w});
    endfunction

    // scoreboard: every held word must match the queue head; pop on transfer
    always @(negedge clk_i) begin
        if (rst_i) begin
            exp_q.delete();
            req_fire = 1'b0;
        end else begin
            if (inst_valid_o) begin
                if (exp_q.size() == 0) begin
                    check_val("sb_unexpected_word", inst_o, 32'hxxxxxxxx);
                end else begin
                    check_val("sb_word", inst_o, exp_q[0][31:0]);
                    check_val("sb_last", 32'(inst_last_o), 32'(exp_q[0][32]));
                    check_val("sb_err", 32'(range_err_o), 32'(exp_q[0][33]));
                    if (inst_ready_i) void'(exp_q.pop_front());
                end
            end
            req_fire = req_valid_i && req_ready_o;
            if (req_fire) model_push(req_sel_i, req_li_i, req_base_i, req_imm_i);
        end
    end

    // driver tasks
    task automatic send(input imm_e sel, input logic li, input logic [31:0] base, input logic [31:0] imm);
        bit done = 0;
        req_valid_i = 1'b1;
        req_sel_i   = sel;
        req_li_i    = li;
        req_base_i  = base;
        req_imm_i   = imm;
        for (int k = 0; k < 50 && !done; k++) begin
            @(posedge clk_i);
            #1;
            done = req_fire;
        end
        req_valid_i = 1'b0;
        if (!done) check_val("send_timeout", 32'd0, 32'd1);
        else check_val("valid_after_accept", 32'(inst_valid_o), 32'd1);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [31:0] rand_imm();
        case ($urandom_range(0, 4))
            0:       return $urandom();
            1:       return 32'($urandom_range(0, 8191)) - 32'd4096;
            2:       return 32'($urandom_range(0, 63)) << $urandom_range(0, 26);
            3:       return $urandom() & 32'hFFFFF000;
            default: return 32'($urandom_range(0, 4095));
        endcase
    endfunction

    initial begin
        rst_i        = 1'b1;
        req_valid_i  = 1'b0;
        req_sel_i    = I_IMM;
        req_li_i     = 1'b0;
        req_base_i   = '0;
        req_imm_i    = '0;
        inst_ready_i = 1'b1;
        repeat (3) tick();
        check_val("rst_valid", 32'(inst_valid_o), 32'd0);
        check_val("rst_inst", inst_o, 32'd0);
        check_val("rst_last", 32'(inst_last_o), 32'd0);
        check_val("rst_err", 32'(range_err_o), 32'd0);
        check_val("rst_ready", 32'(req_ready_o), 32'd0);
        rst_i = 1'b0;
        tick();
        check_val("idle_ready", 32'(req_ready_o), 32'd1);

        send(I_IMM, 1'b0, 32'h00000513, 32'hFFFFFFFF);
        check_val("i_word", inst_o, 32'hFFF00513);
        check_val("i_last", 32'(inst_last_o), 32'd1);
        check_val("i_err", 32'(range_err_o), 32'd0);

        send(B_IMM, 1'b0, 32'h00000063, 32'hFFFFFFFC);
        check_val("b_word", inst_o, 32'hFE000EE3);
        check_val("b_err", 32'(range_err_o), 32'd0);
        send(B_IMM, 1'b0, 32'h00000063, 32'h00001000);
        check_val("b_word_oor", inst_o, 32'h80000063);
        check_val("b_err_oor", 32'(range_err_o), 32'd1);

        send(I_IMM, 1'b1, 32'h00000500, 32'h12345FFF);
        check_val("li_lui", inst_o, 32'h12346537);
        check_val("li_lui_last", 32'(inst_last_o), 32'd0);
        check_val("li_ready_mid", 32'(req_ready_o), 32'd0);
        tick();
        check_val("li_addi", inst_o, 32'hFFF50513);
        check_val("li_addi_last", 32'(inst_last_o), 32'd1);
        tick();

        // backpressure with a request waiting behind the held word
        inst_ready_i = 1'b0;
        send(I_IMM, 1'b0, 32'h00000513, 32'h00000800);
        req_valid_i = 1'b1;
        req_sel_i   = U_IMM;
        req_li_i    = 1'b0;
        req_base_i  = 32'h00000537;
        req_imm_i   = 32'hABCDE000;
        for (int k = 0; k < 5; k++) begin
            check_val("bp_word", inst_o, 32'h80000513);
            check_val("bp_err", 32'(range_err_o), 32'd1);
            check_val("bp_last", 32'(inst_last_o), 32'd1);
            check_val("bp_ready", 32'(req_ready_o), 32'd0);
            tick();
        end
        inst_ready_i = 1'b1;
        #1;
        check_val("bp_release_ready", 32'(req_ready_o), 32'd1);
        tick();
        req_valid_i = 1'b0;
        check_val("bp_next_valid", 32'(inst_valid_o), 32'd1);
        check_val("bp_next_word", inst_o, 32'hABCDE537);
        check_val("bp_next_err", 32'(range_err_o), 32'd0);
        tick();

        // reset while the ADDI is still pending
        inst_ready_i = 1'b0;
        send(I_IMM, 1'b1, 32'h00000500, 32'h12345FFF);
        check_val("rst_mid_lui_last", 32'(inst_last_o), 32'd0);
        rst_i = 1'b1;
        tick();
        check_val("rst_mid_valid", 32'(inst_valid_o), 32'd0);
        check_val("rst_mid_inst", inst_o, 32'd0);
        rst_i = 1'b0;
        inst_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_val("rst_mid_no_addi", 32'(inst_valid_o), 32'd0);
        end

        send(I_IMM, 1'b1, 32'h00000500, 32'h00000123);
`ifdef TCORE_LI_OPT_EN
        check_val("li_short_word", inst_o, 32'h12300513);
        check_val("li_short_last", 32'(inst_last_o), 32'd1);
`else
        check_val("li_small_lui", inst_o, 32'h00000537);
        check_val("li_small_lui_last", 32'(inst_last_o), 32'd0);
        tick();
        check_val("li_small_addi", inst_o, 32'h12350513);
        check_val("li_small_addi_last", 32'(inst_last_o), 32'd1);
`endif
        tick();

        send(imm_e'(3'd7), 1'b0, 32'hDEADBEEF, $urandom());
        check_val("unknown_sel_word", inst_o, 32'hDEADBEEF);
        check_val("unknown_sel_err", 32'(range_err_o), 32'd0);
        tick();

        // randomized traffic with random backpressure
        for (int c = 0; c < 3000; c++) begin
            if (!req_valid_i || req_fire) begin
                req_valid_i = ($urandom_range(0, 3) != 0);
                req_sel_i   = imm_e'(3'($urandom_range(0, 7)));
                req_li_i    = ($urandom_range(0, 3) == 0);
                req_base_i  = $urandom();
                req_imm_i   = rand_imm();
            end
            inst_ready_i = ($urandom_range(0, 3) != 0);
            tick();
        end

        req_valid_i  = 1'b0;
        inst_ready_i = 1'b1;
        for (int k = 0; k < 20 && (inst_valid_o || exp_q.size() != 0); k++) tick();
        check_val("drain_queue_empty", 32'(exp_q.size()), 32'd0);
        check_val("drain_idle", 32'(inst_valid_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
